uart_tx_arbiter: RTL and testbench

Parametrised N-channel arbiter that serialises framed messages from independent sender modules onto a single shared UART transmitter. It sits between the per-message senders (start game, difficulty, map, status, end game, and future ones) and the UART TX, replacing the fixed state-indexed mux. It adds round-robin fairness, per-byte valid/ready streaming, a frame header (SOF + channel id), a maximum-length guard and an optional checksum trailer.

---
 rtl/uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter framing N sender channels onto one UART TX
// Optional checksum trailer enabled by defining UART_ARB_CHECKSUM_EN.
module uart_tx_arbiter #(
    parameter int         NUM_CHANNELS    = 5,
    parameter logic [7:0] SOF_BYTE        = 8'hA5,
    parameter int         MAX_FRAME_BYTES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CHANNELS-1:0]   ch_req,
    input  logic [NUM_CHANNELS-1:0]   ch_valid,
    input  logic [NUM_CHANNELS-1:0]   ch_last,
    input  logic [8*NUM_CHANNELS-1:0] ch_data,
    input  logic                      uart_busy,
    output logic [NUM_CHANNELS-1:0]   ch_grant,
    output logic [NUM_CHANNELS-1:0]   ch_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic                      frame_done,
    output logic                      overflow
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);

    typedef enum logic [2:0] {
        IDLE,
        SEND_SOF,
        SEND_ID,
        FETCH,
        SEND_DATA,
`ifdef UART_ARB_CHECKSUM_EN
        SEND_CSUM,
`endif
        DONE
    } state_t;

    typedef enum logic [1:0] {ISSUE, ACK, DRAIN} phase_t;

    state_t           state;
    state_t           after_send;
    phase_t           phase;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [7:0]       data_q;
    logic             last_q;
    logic [7:0]       pay_cnt;
    logic             ovf_flag;
    logic [7:0]       cur_byte;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             at_limit;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
        return IDX_W'(s);
    endfunction

    // Scan from the highest offset down so the lowest offset at/after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
            if (ch_req[wrap_add(rr_ptr, off)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, off);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_valid = ch_valid[i];
                sel_last  = ch_last[i];
                sel_data  = ch_data[8*i +: 8];
            end
        end
    end

    assign at_limit = (pay_cnt == 8'(MAX_FRAME_BYTES));

    always_comb begin
        cur_byte   = data_q;
        after_send = IDLE;
        case (state)
            SEND_SOF: begin
                cur_byte   = SOF_BYTE;
                after_send = SEND_ID;
            end
            SEND_ID: begin
                cur_byte   = 8'(gnt_idx);
                after_send = FETCH;
            end
            SEND_DATA: begin
                cur_byte = data_q;
`ifdef UART_ARB_CHECKSUM_EN
                after_send = (last_q || at_limit) ? SEND_CSUM : FETCH;
`else
                after_send = (last_q || at_limit) ? DONE : FETCH;
`endif
            end
`ifdef UART_ARB_CHECKSUM_EN
            SEND_CSUM: begin
                cur_byte   = csum_q;
                after_send = DONE;
            end
`endif
            default: begin
                cur_byte   = data_q;
                after_send = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= ISSUE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            pay_cnt    <= '0;
            ovf_flag   <= 1'b0;
            ch_grant   <= '0;
            ch_ready   <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            tx_start   <= 1'b0;
            ch_ready   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        ch_grant <= NUM_CHANNELS'(1) << pick_idx;
                        gnt_idx  <= pick_idx;
                        rr_ptr   <= wrap_add(pick_idx, 1);
                        pay_cnt  <= '0;
                        ovf_flag <= 1'b0;
                        phase    <= ISSUE;
                        state    <= SEND_SOF;
`ifdef UART_ARB_CHECKSUM_EN
                        csum_q   <= 8'(pick_idx);
`endif
                    end
                end
                FETCH: begin
                    if (sel_valid) begin
                        data_q   <= sel_data;
                        last_q   <= sel_last;
                        ch_ready <= ch_grant;
                        pay_cnt  <= pay_cnt + 8'd1;
                        phase    <= ISSUE;
                        state    <= SEND_DATA;
`ifdef UART_ARB_CHECKSUM_EN
                        csum_q   <= csum_q ^ sel_data;
`endif
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    overflow   <= ovf_flag;
                    ch_grant   <= '0;
                    state      <= IDLE;
                end
                default: begin
                    // A new byte is only issued once the UART has visibly taken the previous one.
                    case (phase)
                        ISSUE: begin
                            if (!uart_busy) begin
                                tx_start <= 1'b1;
                                tx_data  <= cur_byte;
                                phase    <= ACK;
                            end
                        end
                        ACK: begin
                            if (uart_busy) phase <= DRAIN;
                        end
                        DRAIN: begin
                            if (!uart_busy) begin
                                if (state == SEND_DATA && !last_q && at_limit) ovf_flag <= 1'b1;
                                phase <= ISSUE;
                                state <= after_send;
                            end
                        end
                        default: phase <= ISSUE;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N = 5;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   ch_req, ch_valid, ch_last, ch_grant, ch_ready;
    logic [8*N-1:0] ch_data;
    logic           uart_busy, tx_start, frame_done, overflow;
    logic [7:0]     tx_data;

    int checks = 0;
    int failures = 0;

    logic [8:0] mem [N][16];
    int wr [N];
    int rd [N];

    logic [7:0] tx_log [$];
    int grant_log [$];
    int done_cnt = 0, ovf_cnt = 0, ovf_bad = 0, ready_cnt = 0, ready_bad = 0;
    int start_twice = 0, busy_viol = 0, busy_cnt = 0, busy_len;
    logic force_busy;
    logic prev_start = 1'b0;
    logic [N-1:0] prev_grant = '0;

    uart_tx_arbiter #(.NUM_CHANNELS(N), .SOF_BYTE(8'hA5), .MAX_FRAME_BYTES(3)) dut (
        .clock(clock), .reset(reset), .ch_req(ch_req), .ch_valid(ch_valid),
        .ch_last(ch_last), .ch_data(ch_data), .uart_busy(uart_busy),
        .ch_grant(ch_grant), .ch_ready(ch_ready), .tx_start(tx_start),
        .tx_data(tx_data), .frame_done(frame_done), .overflow(overflow)
    );

    initial forever #5 clock = ~clock;

    // UART model: busy for busy_len cycles after each tx_start, or forced high.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (busy_cnt > 0) busy_cnt--;
            if (tx_start) begin
                if (uart_busy) busy_viol++;
                busy_cnt = busy_len;
            end
            uart_busy = force_busy || (busy_cnt > 0);
        end
    end

    // Sender model and event recorder.
    initial begin
        ch_valid = '0;
        ch_last  = '0;
        ch_data  = '0;
        for (int i = 0; i < N; i++) rd[i] = 0;
        forever begin
            @(negedge clock);
            if (tx_start) begin
                tx_log.push_back(tx_data);
                if (prev_start) start_twice++;
            end
            prev_start = tx_start;
            if (frame_done) done_cnt++;
            if (frame_done && overflow) ovf_cnt++;
            if (overflow && !frame_done) ovf_bad++;
            ready_cnt += $countones(ch_ready);
            if ((ch_ready & ~ch_grant) != '0) ready_bad++;
            if (ch_grant != prev_grant && ch_grant != '0)
                for (int i = 0; i < N; i++) if (ch_grant[i]) grant_log.push_back(i);
            prev_grant = ch_grant;
            for (int i = 0; i < N; i++) begin
                if (ch_ready[i] && rd[i] < wr[i]) rd[i]++;
                ch_valid[i] = (rd[i] < wr[i]);
                ch_last[i]  = mem[i][rd[i] % 16][8];
                ch_data[8*i +: 8] = mem[i][rd[i] % 16][7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic load(input int ch, input logic [7:0] b, input logic last);
        mem[ch][wr[ch] % 16] = {last, b};
        wr[ch]++;
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) wr[i] = rd[i];
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_cnt < target && n < 1000) begin
            step();
            n++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_log(input string tag, input int base, input int n, input logic [47:0] ev);
        check({tag, "_len"}, 32'(tx_log.size() - base), 32'(n));
        for (int j = 0; j < n; j++)
            check(tag, (base + j < tx_log.size()) ? 32'(tx_log[base + j]) : 32'hFFFF, 32'(ev[47 - 8*j -: 8]));
    endtask

    int b_tx, b_done, b_ovf, b_rdy, b_g, n;

    initial begin
        reset = 1'b1;
        ch_req = '0;
        force_busy = 1'b0;
        busy_len = 4;
        for (int i = 0; i < N; i++) wr[i] = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < 16; j++) mem[i][j] = '0;
        repeat (3) step();
        check("rst_grant", 32'(ch_grant), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();

        // Round robin: channels 0,1,4 request continuously with 1-byte frames.
        load(0, 8'h10, 1'b1); load(0, 8'h11, 1'b1);
        load(1, 8'h20, 1'b1); load(1, 8'h21, 1'b1);
        load(4, 8'h40, 1'b1);
        b_done = done_cnt; b_g = grant_log.size(); b_rdy = ready_cnt;
        ch_req = 5'b10011;
        n = 0;
        while (grant_log.size() < b_g + 5 && n < 2000) begin step(); n++; end
        ch_req = '0;
        wait_done("rr_done", b_done + 5);
        check("rr_grant_cnt", 32'(grant_log.size() - b_g), 32'd5);
        check("rr_g0", 32'(grant_log[b_g + 0]), 32'd0);
        check("rr_g1", 32'(grant_log[b_g + 1]), 32'd1);
        check("rr_g2", 32'(grant_log[b_g + 2]), 32'd4);
        check("rr_g3", 32'(grant_log[b_g + 3]), 32'd0);
        check("rr_g4", 32'(grant_log[b_g + 4]), 32'd1);
        check("rr_ready", 32'(ready_cnt - b_rdy), 32'd5);
        step(); flush(); step();

        // Single frame on channel 2, with request dropped mid-frame.
        load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b1);
        b_tx = tx_log.size(); b_done = done_cnt; b_ovf = ovf_cnt; b_rdy = ready_cnt;
        ch_req = 5'b00100;
        step();
        check("sf_grant", 32'(ch_grant), 32'b00100);
        check("sf_nostart", 32'(tx_start), 32'd0);
        ch_req = '0;
        step();
        check("sf_start", 32'(tx_start), 32'd1);
        check("sf_sof", 32'(tx_data), 32'hA5);
        n = 0;
        while (!frame_done && n < 1000) begin step(); n++; end
        check("sf_done_pulse", 32'(frame_done), 32'd1);
        check("sf_grant_clr", 32'(ch_grant), 32'd0);
        check_log("sf_tx", b_tx, 4 + CS, {8'hA5, 8'h02, 8'h11, 8'h22, 8'h31, 8'h00});
        check("sf_ready", 32'(ready_cnt - b_rdy), 32'd2);
        step();
        check("sf_done_cnt", 32'(done_cnt - b_done), 32'd1);
        check("sf_ovf", 32'(ovf_cnt - b_ovf), 32'd0);
        flush(); step();

        // Busy stall at SOF issue.
        force_busy = 1'b1;
        load(3, 8'h5A, 1'b1);
        step();
        b_tx = tx_log.size(); b_done = done_cnt;
        ch_req = 5'b01000;
        repeat (20) step();
        check("stall_grant", 32'(ch_grant), 32'b01000);
        check("stall_no_tx", 32'(tx_log.size() - b_tx), 32'd0);
        force_busy = 1'b0;
        ch_req = '0;
        wait_done("stall_done", b_done + 1);
        check_log("stall_tx", b_tx, 3 + CS, {8'hA5, 8'h03, 8'h5A, 8'h59, 16'h0});
        step(); flush(); step();

        // Length guard: 5 bytes offered, never last, limit is 3.
        for (int i = 0; i < 5; i++) load(1, 8'h31 + 8'(i), 1'b0);
        b_tx = tx_log.size(); b_done = done_cnt; b_ovf = ovf_cnt; b_rdy = ready_cnt;
        ch_req = 5'b00010;
        step();
        ch_req = '0;
        wait_done("len_done", b_done + 1);
        check("len_ovf", 32'(ovf_cnt - b_ovf), 32'd1);
        check("len_ready", 32'(ready_cnt - b_rdy), 32'd3);
        check_log("len_tx", b_tx, 5 + CS, {8'hA5, 8'h01, 8'h31, 8'h32, 8'h33, 8'h31});
        step();
        check("len_grant_rel", 32'(ch_grant), 32'd0);
        flush(); step();

        // Checksum trailer (present only with the macro).
        load(1, 8'h0F, 1'b0); load(1, 8'hF0, 1'b1);
        b_tx = tx_log.size(); b_done = done_cnt;
        ch_req = 5'b00010;
        step();
        ch_req = '0;
        wait_done("cs_done", b_done + 1);
        check_log("cs_tx", b_tx, 4 + CS, {8'hA5, 8'h01, 8'h0F, 8'hF0, 8'hFE, 8'h00});
        step(); flush(); step();

        // Reset in the middle of a payload byte.
        load(3, 8'h33, 1'b0); load(3, 8'h44, 1'b1);
        b_tx = tx_log.size();
        ch_req = 5'b01000;
        n = 0;
        while (tx_log.size() < b_tx + 3 && n < 1000) begin step(); n++; end
        check("mr_reached", 32'(tx_log.size() - b_tx), 32'd3);
        reset = 1'b1;
        ch_req = '0;
        #1;
        check("mr_tx_start", 32'(tx_start), 32'd0);
        check("mr_grant", 32'(ch_grant), 32'd0);
        check("mr_ready", 32'(ch_ready), 32'd0);
        check("mr_tx_data", 32'(tx_data), 32'd0);
        step(); step();
        reset = 1'b0;
        flush();
        step(); step();
        load(3, 8'h77, 1'b1); load(4, 8'h88, 1'b1);
        b_done = done_cnt;
        ch_req = 5'b11000;
        step();
        check("mr_regrant", 32'(ch_grant), 32'b01000);
        ch_req = '0;
        wait_done("mr_done", b_done + 1);
        check("mr_no_partial", 32'(done_cnt - b_done), 32'd1);

        check("start_one_cycle", 32'(start_twice), 32'd0);
        check("start_while_busy", 32'(busy_viol), 32'd0);
        check("ready_non_granted", 32'(ready_bad), 32'd0);
        check("ovf_without_done", 32'(ovf_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
